// File: rtl/egd_pkg.sv
// Shared types and constants for the Exp-Golomb encoder: mode and FSM encodings,
// datapath widths, and the codeNum mapping for ue(v)/se(v).
package egd_pkg;

  localparam int VAL_W  = 16;
  localparam int INFO_W = 17;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    MODE_UE  = 2'b00,
    MODE_SE  = 2'b01,
    MODE_TE  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ZEROS,
    ST_INFO
  } state_e;

  // se(v) maps v>0 to 2v-1 and v<=0 to -2v; 17 bits holds 65536 for v=-32768.
  function automatic logic [INFO_W-1:0] code_num(input logic [VAL_W-1:0] v, input mode_e m);
    logic [INFO_W-1:0] sv;
    logic [INFO_W-1:0] result;
    sv     = {v[VAL_W-1], v};
    result = {1'b0, v};
    if (m == MODE_SE) begin
      if (!v[VAL_W-1] && (v != '0)) result = {sv[VAL_W-1:0], 1'b0} - INFO_W'(1);
      else                          result = (INFO_W'(0) - sv) << 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/egd_msb_finder.sv
// Combinational index of the most significant set bit of the 17-bit info word
// (returns 0 for an all-zero input).
module egd_msb_finder
  import egd_pkg::*;
(
  input  logic [INFO_W-1:0] value,
  output logic [4:0]        msb_idx
);

  always_comb begin
    // NOTE: default first so no path leaves msb_idx unassigned (no latch).
    msb_idx = '0;
    for (int i = 0; i < INFO_W; i++) begin
      if (value[i]) msb_idx = 5'(i);
    end
  end

endmodule

// File: rtl/exp_golomb_encoder.sv
// Exp-Golomb bit-serial encoder: accepts one ue/se/te syntax element and emits
// N leading zeros followed by info[N:0], MSB first, under bit_valid/bit_ready.
module exp_golomb_encoder
  import egd_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic [1:0]       in_mode,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic [LEN_W-1:0] code_len,
  output logic             busy
);

  state_e            state;
  logic [VAL_W-1:0]  value_q;
  mode_e             mode_q;
  logic [INFO_W-1:0] info_q;
  logic [INFO_W-1:0] info_c;
  logic [4:0]        n_q;
  logic [4:0]        n_c;
  logic [4:0]        cnt;
  logic [4:0]        cnt_dec;
  logic              xfer;

  // te(cMax=1) is a single inverted bit; forcing info to 0/1 also forces N=0.
  assign info_c  = (mode_q == MODE_TE) ? {{(INFO_W-1){1'b0}}, ~value_q[0]}
                                       : code_num(value_q, mode_q) + INFO_W'(1);
  assign cnt_dec = cnt - 5'd1;
  assign xfer    = bit_valid && bit_ready;
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  egd_msb_finder u_msb (
    .value   (info_c),
    .msb_idx (n_c)
  );

  // NOTE: datapath registers are only read after being loaded, so they carry no reset.
  always_ff @(posedge wb_clk_i) begin
    if (state == ST_IDLE && in_valid) begin
      value_q <= in_value;
      mode_q  <= mode_e'(in_mode);
    end
    if (state == ST_PREP) begin
      info_q <= info_c;
      n_q    <= n_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      code_len  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) state <= ST_PREP;
        end
        ST_PREP: begin
          code_len  <= {n_c, 1'b1};
          bit_valid <= 1'b1;
          if (n_c != '0) begin
            state    <= ST_ZEROS;
            cnt      <= n_c;
            bit_out  <= 1'b0;
            bit_last <= 1'b0;
          end else begin
            state    <= ST_INFO;
            cnt      <= '0;
            bit_out  <= info_c[0];
            bit_last <= 1'b1;
          end
        end
        ST_ZEROS: begin
          if (xfer) begin
            if (cnt == 5'd1) begin
              state   <= ST_INFO;
              cnt     <= n_q;
              bit_out <= info_q[n_q];
            end else begin
              cnt <= cnt_dec;
            end
          end
        end
        ST_INFO: begin
          if (xfer) begin
            if (cnt == '0) begin
              state     <= ST_IDLE;
              bit_valid <= 1'b0;
              bit_out   <= 1'b0;
              bit_last  <= 1'b0;
            end else begin
              cnt      <= cnt_dec;
              bit_out  <= info_q[cnt_dec];
              bit_last <= (cnt == 5'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exp_golomb_encoder.md
EXP_GOLOMB_ENCODER -- requirements
Module: exp_golomb_encoder

Interface
REQ-001 SHALL have port wb_clk_i, input, 1, the only clock; all logic on its rising edge.
REQ-002 SHALL have port wb_rst_ni, input, 1, synchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, syntax element offered.
REQ-004 SHALL have port in_ready, output, 1, encoder accepts the element.
REQ-005 SHALL have port in_value, input, 16, element value: unsigned for ue/te, two's complement for se.
REQ-006 SHALL have port in_mode, input, 2, encoding: 00 ue(v), 01 se(v), 10 te(v) with cMax=1, 11 treated as ue(v).
REQ-007 SHALL have port bit_out, output, 1, current bitstream bit.
REQ-008 SHALL have port bit_valid, output, 1, bit_out is valid.
REQ-009 SHALL have port bit_ready, input, 1, sink consumes the bit.
REQ-010 SHALL have port bit_last, output, 1, bit_out is the final bit of the codeword.
REQ-011 SHALL have port code_len, output, 6, total codeword length, held from PREP until the next accept.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ZEROS and INFO.
REQ-014 in_ready SHALL equal (state==IDLE).
REQ-015 An element SHALL be accepted when in_valid && in_ready; value and mode are registered and the FSM moves to PREP.
REQ-016 ue: codeNum = in_value (17-bit zero-extended).
REQ-017 se: codeNum = 2v-1 for v>0 and -2v for v<=0, computed in 17 bits; v=-32768 gives 65536.
REQ-018 te(cMax=1): the codeword SHALL be the single bit ~in_value[0]; N=0, no ZEROS state.
REQ-019 In PREP, info = codeNum+1 (17 bits, max 65537) and N = index of the MSB of info (0..16); code_len = 2N+1 (te: 1).
REQ-020 PREP SHALL last exactly 1 cycle, then go to ZEROS if N>0, else to INFO.
REQ-021 ZEROS SHALL emit N '0' bits; INFO SHALL emit info[N] down to info[0], MSB first.
REQ-022 A bit SHALL advance only on bit_valid && bit_ready; while bit_ready is low, bit_out, bit_last and bit_valid SHALL hold.
REQ-023 bit_valid SHALL be high throughout ZEROS and INFO and low in IDLE and PREP.
REQ-024 bit_last SHALL be high only on info[0].
REQ-025 On transfer of the last bit the FSM SHALL return to IDLE; the next accept is possible the following cycle.
REQ-026 Latency: accept at cycle T, first bit_valid at T+2; sustained rate 1 bit/cycle with bit_ready held high.
REQ-027 Maximum codeword length SHALL be 33 bits (ue 65535, se -32768); no truncation.

Reset
REQ-028 While wb_rst_ni=0 at a clock edge, state SHALL become IDLE, and bit_out, bit_valid, bit_last, busy and code_len SHALL become 0.
REQ-029 Reset mid-codeword SHALL abort the codeword without emitting further bits; in_ready=1 on the first cycle after release.

Structure
REQ-030 Shared package egd_pkg SHALL hold the in_mode encoding enum, the FSM state enum, and the constants VAL_W=16, INFO_W=17, LEN_W=6.
REQ-031 The MSB index of info SHALL be computed in sub-module egd_msb_finder (17-bit input, 5-bit index output, purely combinational).

Verification
REQ-032 ue 0 -> bits "1", code_len=1, bit_last on bit 1; ue 3 -> "00100", code_len=5.
REQ-033 se +1 -> "010"; se -2 -> "00101"; se 0 -> "1".
REQ-034 ue 65535 -> 16 '0' + '1' + 16 '0', code_len=33; se -32768 -> 16 '0' + "1" + 15 '0' + "1", code_len=33.
REQ-035 te value 0 -> "1"; te value 1 -> "0"; both with code_len=1 and first bit_valid at T+2.
REQ-036 ue 3 with bit_ready low for 4 cycles after bit 2 -> bit_out holds 1 with bit_valid high; stream completes as "00100".
REQ-037 wb_rst_ni low for 1 cycle after bit 5 of ue 65535 -> bit_valid=0 next cycle, busy=0, in_ready=1 after release; next ue 0 -> "1".
